run_light_mode_ctrl: RTL
========================

Name: run_light_mode_ctrl

Overview:
- Front-end control stage placed directly upstream of the run-light pattern generator.
- Debounces two raw push-buttons (next/prev) and maintains the 3-bit pattern-mode select S (0..4) that drives the generator.
- Generates a slow step-enable tick, so the pattern advances at a visible rate instead of every clk.
- Flags every mode change with a one-cycle pulse, so the generator can restart its pattern from the beginning.

Parameters:
- DB_CYCLES, 20, consecutive clocks a synchronized key level must differ from the filtered level before the filtered level updates (min 2)
- STEP_DIV, 4, clocks per step_en pulse (min 2)
- NUM_MODES, 5, number of legal S values, 0..NUM_MODES-1 (max 8)
- AUTO_STEPS, 32, step_en pulses per mode before auto-advance (used only with the optional feature)

Ports:
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
- key_next  input  1  raw button, active-low (0 = pressed), asynchronous to clk
- key_prev  input  1  raw button, active-low, asynchronous to clk
- S  output  3  registered mode select for the downstream run-light block
- step_en  output  1  registered one-cycle pulse, pattern step strobe
- mode_chg  output  1  registered one-cycle pulse, high in the cycle S holds its new value

Behaviour:
- Reset (reset=0, asynchronous):
  - S=0, step_en=0, mode_chg=0.
  - Both 2-FF synchronizers = 1, filtered key levels = 1.
  - Debounce counters, step divider and auto counter = 0.
  - Assertion mid-operation aborts any debounce or step in progress. No event is generated on release of reset.
- Synchronizer: each key passes through a 2-FF chain before any use.
- Debounce, per key:
  - cnt increments while sync != filt and clears to 0 when they are equal.
  - At the edge where sync != filt and cnt == DB_CYCLES-1: filt <= sync, cnt <= 0.
  - cnt width is $clog2(DB_CYCLES).
- Press event: filt falling edge (1->0), detected against a registered copy of filt. Exactly one event per press, however long the key is held. Release (0->1) produces no event. A glitch shorter than DB_CYCLES clocks produces no event.
- Latency: S and mode_chg change at clock edge DB_CYCLES+3, counting the first edge at which the raw key is sampled low as edge 1.
- Mode update, on the event edge:
  - next alone: S <= (S==NUM_MODES-1) ? 0 : S+1.
  - prev alone: S <= (S==0) ? NUM_MODES-1 : S-1.
  - next and prev events in the same cycle: both ignored; S, mode_chg and the counters are unchanged.
  - mode_chg=1 for exactly the one cycle following the S update.
- Step divider:
  - Counts 0..STEP_DIV-1; step_en=1 for one cycle each time the count wraps to 0.
  - Any mode change reloads the divider to 0, so the first step_en in the new mode comes STEP_DIV clocks after mode_chg.
  - step_en is held at 0 while S==NUM_MODES-1, the clear/reset pattern mode; the divider keeps counting.
- Out-of-range S is unreachable. Width: S is 3 bits; the arithmetic is done in 3 bits, with explicit wrap as above.

Optional Feature:
- Macro: RUN_LIGHT_AUTO_CYCLE_EN
- Defined:
  - A counter of step_en pulses in the current mode clears on every mode change.
  - On reaching AUTO_STEPS, S auto-advances as for next, except that S==NUM_MODES-2 wraps to 0. Auto mode never enters, and never runs in, mode NUM_MODES-1.
  - Auto-advance pulses mode_chg and reloads the step divider.
  - A key event in the same cycle as auto-advance takes priority; the auto counter clears.
- Undefined: the auto counter is not present. S changes only on key events.

Test Plan (DB_CYCLES=4, STEP_DIV=4, NUM_MODES=5):
- Reset low with keys idle high, then release -> S=0, step_en=0, mode_chg=0. First step_en comes 4 clocks after release and repeats every 4 clocks.
- key_next held low for 20 clocks from edge 1 -> S: 0->1 at edge 7, mode_chg high 1 cycle, no further change during hold or on release.
- key_next low for 3 clocks only, then high -> no S change, no mode_chg.
- Five next presses from S=0 -> S sequence 1,2,3,4,0. step_en stays 0 while S=4. One prev press from S=0 -> S=4.
- next and prev pressed on the same clock for 10 clocks -> S unchanged, no mode_chg.
- Reset pulled low 2 clocks into a debounce, then released -> S=0, no event afterwards. With RUN_LIGHT_AUTO_CYCLE_EN and AUTO_STEPS=3: S 0->1 after the 3rd step_en; from S=3 the auto-advance goes to 0.

Source files
------------

// File: rtl/run_light_mode_ctrl.sv
// Run-light front end: debounced next/prev keys drive mode select S, plus step strobe and mode-change pulse.
// Define RUN_LIGHT_AUTO_CYCLE_EN to auto-advance S after AUTO_STEPS step pulses in one mode.
module run_light_mode_ctrl #(
    parameter int unsigned DB_CYCLES  = 20,
    parameter int unsigned STEP_DIV   = 4,
    parameter int unsigned NUM_MODES  = 5,
    parameter int unsigned AUTO_STEPS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_next,
    input  logic       key_prev,
    output logic [2:0] S,
    output logic       step_en,
    output logic       mode_chg
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam int unsigned DW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
    localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);

    if (DB_CYCLES < 2 || STEP_DIV < 2 || NUM_MODES < 2 || NUM_MODES > 8 || AUTO_STEPS < 1) begin : g_param_check
        $error("run_light_mode_ctrl: illegal parameter set");
    end

    // Key vectors: bit 0 = next, bit 1 = prev.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         filt_q, filt_d;
    logic [1:0]         filt_prev_q, filt_prev_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         press;

    logic [2:0]    s_q, s_d;
    logic          step_en_q, step_en_d;
    logic          mode_chg_q, mode_chg_d;
    logic [DW-1:0] div_q, div_d;
    logic          chg;

`ifdef RUN_LIGHT_AUTO_CYCLE_EN
    localparam int unsigned AW = $clog2(AUTO_STEPS + 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STEPS - 1);
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_fire;
`endif

    always_comb begin
        sync1_d     = {key_prev, key_next};
        sync2_d     = sync1_q;
        filt_d      = filt_q;
        cnt_d       = cnt_q;
        filt_prev_d = filt_q;
        for (int unsigned k = 0; k < 2; k++) begin
            if (sync2_q[k] != filt_q[k]) begin
                if (cnt_q[k] == DB_LAST) begin
                    filt_d[k] = sync2_q[k];
                    cnt_d[k]  = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
        press = filt_prev_q & ~filt_q;
    end

    always_comb begin
        s_d = s_q;
        chg = 1'b0;
`ifdef RUN_LIGHT_AUTO_CYCLE_EN
        auto_fire = step_en_q && (auto_cnt_q == AUTO_LAST) && (s_q != MODE_LAST);
`endif
        case (press)
            2'b01: begin
                s_d = (s_q == MODE_LAST) ? '0 : s_q + 3'd1;
                chg = 1'b1;
            end
            2'b10: begin
                s_d = (s_q == '0) ? MODE_LAST : s_q - 3'd1;
                chg = 1'b1;
            end
            default: begin
`ifdef RUN_LIGHT_AUTO_CYCLE_EN
                // Auto cycling skips the clear mode: the last run mode wraps straight to 0.
                if (press == 2'b00 && auto_fire) begin
                    s_d = (s_q == MODE_LAST - 3'd1) ? '0 : s_q + 3'd1;
                    chg = 1'b1;
                end
`endif
            end
        endcase

        mode_chg_d = chg;
        if (chg) begin
            div_d     = '0;
            step_en_d = 1'b0;
        end else begin
            div_d     = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            step_en_d = (div_q == DIV_LAST) && (s_q != MODE_LAST);
        end

`ifdef RUN_LIGHT_AUTO_CYCLE_EN
        if (chg) begin
            auto_cnt_d = '0;
        end else if (press == 2'b11) begin
            auto_cnt_d = auto_cnt_q;
        end else if (step_en_q) begin
            auto_cnt_d = auto_cnt_q + AW'(1);
        end else begin
            auto_cnt_d = auto_cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            filt_q      <= '1;
            filt_prev_q <= '1;
            cnt_q       <= '0;
            s_q         <= '0;
            step_en_q   <= 1'b0;
            mode_chg_q  <= 1'b0;
            div_q       <= '0;
`ifdef RUN_LIGHT_AUTO_CYCLE_EN
            auto_cnt_q  <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            step_en_q   <= step_en_d;
            mode_chg_q  <= mode_chg_d;
            div_q       <= div_d;
`ifdef RUN_LIGHT_AUTO_CYCLE_EN
            auto_cnt_q  <= auto_cnt_d;
`endif
        end
    end

    assign S        = s_q;
    assign step_en  = step_en_q;
    assign mode_chg = mode_chg_q;

endmodule
